// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable data width,
// runtime parity (none/even/odd), 1 or 2 stop bits, a 2-flop input
// synchroniser, 3-sample majority voting, false-start rejection and
// parity / framing / break reporting.
//
// Output handshake: o_valid is a single-cycle strobe with no ready. In the
// cycle o_valid is high, o_data, o_parity_err, o_frame_err and o_break
// carry the new frame's values; they hold until the next strobe or reset.
module uart_rx_cfg #(
  parameter int CLK_FR     = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DBIT       = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_parity_en,
  input  logic            i_parity_odd,
  output logic [DBIT-1:0] o_data,
  output logic            o_valid,
  output logic            o_parity_err,
  output logic            o_frame_err,
  output logic            o_break,
  output logic            o_busy
);

  localparam int DIV   = CLK_FR / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DBIT);
  localparam int M     = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [S_W-1:0]   s_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             stop_cnt;
  logic [1:0]       smp;       // [0] = sample at M-1, [1] = sample at M
  logic [DBIT-1:0]  shreg;
  logic             par_en_l;
  logic             par_odd_l;
  logic             par_err_l;
  logic             par_bit_l;
  logic             ferr_l;
  logic             tick;
  logic             mid;
  logic             last;
  logic             maj;
  logic             fe_final;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversample divider, re-phased to the detected start edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_cnt <= '0;
    end else if (state == IDLE && !rx_s) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Tick strobe, in-bit position decodes and the 3-sample majority vote.
  always_comb begin
    tick     = (div_cnt == DIV_W'(DIV - 1));
    mid      = (s_cnt == S_W'(M + 1));
    last     = (s_cnt == S_W'(OVERSAMPLE - 1));
    maj      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    fe_final = ferr_l | ~maj;
  end

  assign o_busy = (state != IDLE);

  // Receive FSM: bit timing, sampling, shifting, checking and output update.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      smp          <= 2'b11;
      shreg        <= '0;
      par_en_l     <= 1'b0;
      par_odd_l    <= 1'b0;
      par_err_l    <= 1'b0;
      par_bit_l    <= 1'b0;
      ferr_l       <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          s_cnt <= '0;
          if (!rx_s) begin
            state     <= START;
            par_en_l  <= i_parity_en;
            par_odd_l <= i_parity_odd;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_err_l <= 1'b0;
            par_bit_l <= 1'b0;
            ferr_l    <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          // A held-low line must return high before a new start is accepted.
          if (rx_s) state <= IDLE;
        end
        default: begin
          if (tick) begin
            s_cnt <= last ? '0 : s_cnt + 1'b1;
            if (s_cnt == S_W'(M - 1)) smp[0] <= rx_s;
            if (s_cnt == S_W'(M))     smp[1] <= rx_s;
            case (state)
              START: begin
                if (mid && maj) state <= IDLE;
                else if (last)  state <= DATA;
              end
              DATA: begin
                if (mid) shreg <= {maj, shreg[DBIT-1:1]};
                if (last) begin
                  if (bit_cnt == BIT_W'(DBIT - 1)) begin
                    bit_cnt <= '0;
                    state   <= par_en_l ? PARITY : STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
              end
              PARITY: begin
                if (mid) begin
                  par_bit_l <= maj;
                  par_err_l <= ((^shreg) ^ maj) != par_odd_l;
                end
                if (last) state <= STOP;
              end
              STOP: begin
                if (mid) begin
                  if (stop_cnt == 1'(STOP_BITS - 1)) begin
                    // Deliver at mid-bit so a back-to-back start is not missed.
                    o_valid      <= 1'b1;
                    o_data       <= shreg;
                    o_parity_err <= par_en_l & par_err_l;
                    o_frame_err  <= fe_final;
                    o_break      <= (shreg == '0) & ~par_bit_l & fe_final;
                    state        <= maj ? IDLE : WAIT_HIGH;
                  end else if (!maj) begin
                    ferr_l <= 1'b1;
                  end
                end
                if (last) stop_cnt <= stop_cnt + 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
